// File: rtl/lpm_bustri_pkg.sv
// Shared definitions for the bus tri-state sequencer: state encoding and counter sizing.
// No logic, no latency.
// No flow control.
package lpm_bustri_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_DRIVE = 2'd1;
  localparam state_t ST_RECV  = 2'd2;
  localparam state_t ST_TURN  = 2'd3;

  // Width of the phase counter: enough bits for the longest phase, plus one.
  function automatic int cnt_width(input int drive_cycles, input int read_latency,
                                   input int turnaround);
    int m;
    m = drive_cycles;
    if (read_latency > m) m = read_latency;
    if (turnaround > m) m = turnaround;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/lpm_bustri_cnt.sv
// Loadable down-counter with a zero flag, timing the DRIVE, RECV and TURN phases.
// Load/decrement take effect at the next clock edge; zero is combinational from the count.
// No flow control; load has priority over decrement, and decrement saturates at zero.
module lpm_bustri_cnt #(
  parameter int cnt_w = 2
) (
  input  logic             clock,
  input  logic             sclr,
  input  logic             load,
  input  logic [cnt_w-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [cnt_w-1:0] count_q;
  logic [cnt_w-1:0] count_d;

  // Next count: load a phase length, or step down towards zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge clock) begin
    if (sclr) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/lpm_bustri_ctrl.sv
// Sequences write-drive / read-receive / turnaround phases for one tri-state bus buffer.
// Enables change one cycle after request acceptance; read data appears L+1 cycles after acceptance.
// Accepts a request only while ready=1; requests seen while busy are dropped, not queued.
module lpm_bustri_ctrl
  import lpm_bustri_pkg::*;
#(
  parameter int lpm_width        = 8,
  parameter int lpm_drive_cycles = 1,
  parameter int lpm_read_latency = 1,
  parameter int lpm_turnaround   = 1
) (
  input  logic                 clock,
  input  logic                 sclr,
  input  logic                 wr_req,
  input  logic [lpm_width-1:0] wr_data,
  input  logic                 rd_req,
  output logic                 ready,
  output logic [lpm_width-1:0] rd_data,
  output logic                 rd_valid,
  input  logic [lpm_width-1:0] bus_result,
  output logic [lpm_width-1:0] data,
  output logic                 enabledt,
  output logic                 enabletr
);

  localparam int CNT_W = cnt_width(lpm_drive_cycles, lpm_read_latency, lpm_turnaround);

  // The counter holds "cycles remaining minus one", so a phase ends when it reads zero.
  localparam logic [CNT_W-1:0] DRIVE_LOAD = CNT_W'(lpm_drive_cycles - 1);
  localparam logic [CNT_W-1:0] RECV_LOAD  = CNT_W'(lpm_read_latency - 1);
  localparam logic [CNT_W-1:0] TURN_LOAD  =
    CNT_W'((lpm_turnaround > 0) ? (lpm_turnaround - 1) : 0);
  localparam bit HAS_TURN = (lpm_turnaround > 0);

  state_t                 state_q, state_d;
  logic [lpm_width-1:0]   data_q, data_d;
  logic [lpm_width-1:0]   rd_data_q, rd_data_d;
  logic                   rd_valid_q, rd_valid_d;
  logic                   enabledt_q, enabledt_d;
  logic                   enabletr_q, enabletr_d;

  logic                   cnt_load;
  logic [CNT_W-1:0]       cnt_val;
  logic                   cnt_dec;
  logic                   cnt_zero;

  lpm_bustri_cnt #(
    .cnt_w(CNT_W)
  ) u_cnt (
    .clock   (clock),
    .sclr    (sclr),
    .load    (cnt_load),
    .load_val(cnt_val),
    .dec     (cnt_dec),
    .zero    (cnt_zero)
  );

  // State and registered outputs; reset drops both enables immediately.
  always_ff @(posedge clock) begin
    if (sclr) begin
      state_q    <= ST_IDLE;
      data_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      enabledt_q <= 1'b0;
      enabletr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      enabledt_q <= enabledt_d;
      enabletr_q <= enabletr_d;
    end
  end

  // Next state and phase-counter control; writes win over simultaneous reads.
  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wr_req) begin
          state_d  = ST_DRIVE;
          cnt_load = 1'b1;
          cnt_val  = DRIVE_LOAD;
        end else if (rd_req) begin
          state_d  = ST_RECV;
          cnt_load = 1'b1;
          cnt_val  = RECV_LOAD;
        end
      end
      ST_DRIVE, ST_RECV: begin
        if (cnt_zero) begin
          if (HAS_TURN) begin
            state_d  = ST_TURN;
            cnt_load = 1'b1;
            cnt_val  = TURN_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_TURN: begin
        if (cnt_zero) begin
          state_d = ST_IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; enables are mutually exclusive by construction.
  always_comb begin
    data_d     = data_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    enabledt_d = 1'b0;
    enabletr_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wr_req) begin
          data_d     = wr_data;
          enabledt_d = 1'b1;
        end else if (rd_req) begin
          enabletr_d = 1'b1;
        end
      end
      ST_DRIVE: enabledt_d = !cnt_zero;
      ST_RECV: begin
        if (cnt_zero) begin
          rd_data_d  = bus_result;
          rd_valid_d = 1'b1;
        end else begin
          enabletr_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign ready    = (state_q == ST_IDLE);
  assign data     = data_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign enabledt = enabledt_q;
  assign enabletr = enabletr_q;

endmodule

// File: tb/tb_lpm_bustri_ctrl.sv
// Bench for lpm_bustri_ctrl: two instances (D=2,L=3,T=1 and D=1,L=1,T=0) on shared inputs.
// A per-cycle timeline model predicts every output; vector table and hand sequences add fixed checks.
// Inputs change on the falling edge, outputs are sampled on the falling edge after each rising edge.
module tb_lpm_bustri_ctrl;

  localparam int DP[2] = '{2, 1};
  localparam int LP[2] = '{3, 1};
  localparam int TP[2] = '{1, 0};

  logic       clock;
  logic       sclr;
  logic       wr_req;
  logic       rd_req;
  logic [7:0] wr_data;
  logic [7:0] bus_result;

  logic [1:0] ready_o;
  logic [1:0] rd_valid_o;
  logic [1:0] enabledt_o;
  logic [1:0] enabletr_o;
  logic [7:0] rd_data_o [2];
  logic [7:0] data_o    [2];

  lpm_bustri_ctrl #(
    .lpm_width(8), .lpm_drive_cycles(2), .lpm_read_latency(3), .lpm_turnaround(1)
  ) dut_a (
    .clock(clock), .sclr(sclr), .wr_req(wr_req), .wr_data(wr_data), .rd_req(rd_req),
    .ready(ready_o[0]), .rd_data(rd_data_o[0]), .rd_valid(rd_valid_o[0]),
    .bus_result(bus_result), .data(data_o[0]),
    .enabledt(enabledt_o[0]), .enabletr(enabletr_o[0])
  );

  lpm_bustri_ctrl #(
    .lpm_width(8), .lpm_drive_cycles(1), .lpm_read_latency(1), .lpm_turnaround(0)
  ) dut_b (
    .clock(clock), .sclr(sclr), .wr_req(wr_req), .wr_data(wr_data), .rd_req(rd_req),
    .ready(ready_o[1]), .rd_data(rd_data_o[1]), .rd_valid(rd_valid_o[1]),
    .bus_result(bus_result), .data(data_o[1]),
    .enabledt(enabledt_o[1]), .enabletr(enabletr_o[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Timeline model: cycle c is the cycle that ends at rising edge c.
  int         edge_n = 0;
  bit         model_on = 0;
  int         ready_from [2];
  int         de_lo [2], de_hi [2];
  int         tr_lo [2], tr_hi [2];
  int         cap_edge [2];
  int         rdv_cyc [2];
  logic [7:0] data_exp [2];
  logic [7:0] rdat_exp [2];

  task automatic model_edge();
    int k;
    k = edge_n;
    for (int i = 0; i < 2; i++) begin
      if (sclr) begin
        ready_from[i] = k + 1;
        de_lo[i] = 1; de_hi[i] = 0;
        tr_lo[i] = 1; tr_hi[i] = 0;
        cap_edge[i] = -1;
        rdv_cyc[i]  = -1;
        data_exp[i] = 8'h00;
        rdat_exp[i] = 8'h00;
      end else if (model_on) begin
        if (cap_edge[i] == k) begin
          rdat_exp[i] = bus_result;
          rdv_cyc[i]  = k + 1;
          cap_edge[i] = -1;
        end
        if (k >= ready_from[i]) begin
          if (wr_req) begin
            data_exp[i]   = wr_data;
            de_lo[i]      = k + 1;
            de_hi[i]      = k + DP[i];
            ready_from[i] = k + DP[i] + TP[i] + 1;
          end else if (rd_req) begin
            tr_lo[i]      = k + 1;
            tr_hi[i]      = k + LP[i];
            cap_edge[i]   = k + LP[i];
            ready_from[i] = k + LP[i] + TP[i] + 1;
          end
        end
      end
    end
    if (sclr) model_on = 1;
  endtask

  task automatic model_check();
    int c;
    c = edge_n + 1;
    if (!model_on) return;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("m%0d.ready", i), 32'(ready_o[i]), 32'(c >= ready_from[i]));
      chk($sformatf("m%0d.enabledt", i), 32'(enabledt_o[i]),
          32'((c >= de_lo[i]) && (c <= de_hi[i])));
      chk($sformatf("m%0d.enabletr", i), 32'(enabletr_o[i]),
          32'((c >= tr_lo[i]) && (c <= tr_hi[i])));
      chk($sformatf("m%0d.rd_valid", i), 32'(rd_valid_o[i]), 32'(c == rdv_cyc[i]));
      chk($sformatf("m%0d.data", i), 32'(data_o[i]), 32'(data_exp[i]));
      chk($sformatf("m%0d.rd_data", i), 32'(rd_data_o[i]), 32'(rdat_exp[i]));
      chk($sformatf("m%0d.excl", i), 32'(enabledt_o[i] & enabletr_o[i]), 32'd0);
    end
  endtask

  // One clock: model sees the inputs present at the rising edge, outputs checked at the falling edge.
  task automatic step();
    @(posedge clock);
    edge_n++;
    model_edge();
    @(negedge clock);
    model_check();
  endtask

  task automatic drive(input logic s, input logic w, input logic r,
                       input logic [7:0] wd, input logic [7:0] br);
    sclr = s; wr_req = w; rd_req = r; wr_data = wd; bus_result = br;
  endtask

  typedef struct {
    logic       s, w, r;
    logic [7:0] wd, br;
    logic       e_rdy, e_edt, e_etr;
    logic [7:0] e_data;
    logic       e_rdv;
    logic [7:0] e_rdat;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic w, input logic r,
                              input logic [7:0] wd, input logic [7:0] br,
                              input logic e_rdy, input logic e_edt, input logic e_etr,
                              input logic [7:0] e_data, input logic e_rdv,
                              input logic [7:0] e_rdat);
    vec_t v;
    v.s = s; v.w = w; v.r = r; v.wd = wd; v.br = br;
    v.e_rdy = e_rdy; v.e_edt = e_edt; v.e_etr = e_etr;
    v.e_data = e_data; v.e_rdv = e_rdv; v.e_rdat = e_rdat;
    return v;
  endfunction

  vec_t tbl [17];

  initial begin
    // Instance A (D=2, L=3, T=1): reset with wr_req held, write A5, read 3C, write+read together.
    tbl[0]  = mk(1'b1, 1'b1, 1'b0, 8'hA5, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    tbl[1]  = mk(1'b1, 1'b1, 1'b0, 8'hA5, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    tbl[2]  = mk(1'b1, 1'b1, 1'b0, 8'hA5, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    tbl[3]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    tbl[4]  = mk(1'b0, 1'b1, 1'b0, 8'hA5, 8'hFF, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 8'h00);
    tbl[5]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 8'h00);
    tbl[6]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 8'h00);
    tbl[7]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 8'h00);
    tbl[8]  = mk(1'b0, 1'b0, 1'b1, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 8'h00);
    tbl[9]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 8'h00);
    tbl[10] = mk(1'b0, 1'b0, 1'b0, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 8'h00);
    tbl[11] = mk(1'b0, 1'b0, 1'b0, 8'h00, 8'h3C, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 8'h3C);
    tbl[12] = mk(1'b0, 1'b0, 1'b0, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 8'h3C);
    tbl[13] = mk(1'b0, 1'b1, 1'b1, 8'h5A, 8'hFF, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b0, 8'h3C);
    tbl[14] = mk(1'b0, 1'b0, 1'b0, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b0, 8'h3C);
    tbl[15] = mk(1'b0, 1'b0, 1'b0, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 8'h3C);
    tbl[16] = mk(1'b0, 1'b0, 1'b0, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b0, 8'h3C);

    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'hFF);
    @(negedge clock);

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].s, tbl[i].w, tbl[i].r, tbl[i].wd, tbl[i].br);
      step();
      chk($sformatf("vec%0d.ready", i),    32'(ready_o[0]),    32'(tbl[i].e_rdy));
      chk($sformatf("vec%0d.enabledt", i), 32'(enabledt_o[0]), 32'(tbl[i].e_edt));
      chk($sformatf("vec%0d.enabletr", i), 32'(enabletr_o[0]), 32'(tbl[i].e_etr));
      chk($sformatf("vec%0d.data", i),     32'(data_o[0]),     32'(tbl[i].e_data));
      chk($sformatf("vec%0d.rd_valid", i), 32'(rd_valid_o[0]), 32'(tbl[i].e_rdv));
      chk($sformatf("vec%0d.rd_data", i),  32'(rd_data_o[0]),  32'(tbl[i].e_rdat));
    end

    // Reset during the second receive cycle of a read on instance A.
    drive(1'b0, 1'b0, 1'b1, 8'h00, 8'h77);
    step();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h77);
    step();
    chk("midrst.pre_etr", 32'(enabletr_o[0]), 32'd1);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h77);
    step();
    chk("midrst.etr", 32'(enabletr_o[0]), 32'd0);
    chk("midrst.rdv", 32'(rd_valid_o[0]), 32'd0);
    chk("midrst.rd_data", 32'(rd_data_o[0]), 32'd0);
    chk("midrst.ready", 32'(ready_o[0]), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h77);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("midrst.no_rdv%0d", i), 32'(rd_valid_o[0]), 32'd0);
    end

    // Back-to-back writes on instance B (T=0): drive, idle, drive, idle.
    drive(1'b0, 1'b1, 1'b0, 8'h01, 8'h00);
    step();
    chk("b2b.edt1", 32'(enabledt_o[1]), 32'd1);
    chk("b2b.data1", 32'(data_o[1]), 32'h01);
    drive(1'b0, 1'b1, 1'b0, 8'h02, 8'h00);
    step();
    chk("b2b.gap_edt", 32'(enabledt_o[1]), 32'd0);
    chk("b2b.gap_ready", 32'(ready_o[1]), 32'd1);
    chk("b2b.gap_data", 32'(data_o[1]), 32'h01);
    step();
    chk("b2b.edt2", 32'(enabledt_o[1]), 32'd1);
    chk("b2b.data2", 32'(data_o[1]), 32'h02);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    step();
    chk("b2b.end_edt", 32'(enabledt_o[1]), 32'd0);
    chk("b2b.end_etr", 32'(enabletr_o[1]), 32'd0);

    // Random traffic with occasional resets, checked against the timeline model.
    for (int n = 0; n < 3000; n++) begin
      drive(1'($urandom_range(0, 96) == 0),
            1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 2) == 0),
            8'($urandom), 8'($urandom));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
